// File: rtl/cpu_fpu_requester.sv
// Initiator side of the FPU request/ready handshake: one operation at a time, routed to add/mul/div/sqrt.
// Optional per-phase watchdog enabled by defining CPU_FPU_TIMEOUT_EN.
`timescale 1ns/1ps
module cpu_fpu_requester #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_issue,
    input  logic [1:0]   i_unit,
    input  logic [31:0]  i_op1,
    input  logic [31:0]  i_op2,
    output logic         o_busy,
    output logic         o_done,
    output logic [31:0]  o_result,
    output logic         o_timeout,
    output logic [3:0]   o_request,
    output logic [31:0]  o_op1,
    output logic [31:0]  o_op2,
    input  logic [3:0]   i_ready,
    input  logic [127:0] i_result,
    output logic [2:0]   o_state
);

    // Handshake: raise request[unit] only once that unit's ready is low; ready high while
    // requested means the result is valid; drop request and wait for ready to fall before done.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        REQUEST = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [9:0]  WD_LIMIT  = 10'(TIMEOUT_CYCLES);
    localparam logic [31:0] QUIET_NAN = 32'h7FC0_0000;

    state_t      state;
    state_t      state_next;
    logic [1:0]  unit;
    logic [1:0]  unit_next;
    logic        issue_take;
    logic        ready_sel;
    logic [31:0] result_sel;
    logic        timeout_hit;
    logic        busy_state;

    assign issue_take = ((state == IDLE) || (state == DONE)) && i_issue;
    assign unit_next  = issue_take ? i_unit : unit;
    assign ready_sel  = i_ready[unit];
    assign result_sel = i_result[{unit, 5'd0} +: 32];
    assign busy_state = (state == DRAIN) || (state == REQUEST) || (state == RELEASE);
    assign o_state    = state;

`ifdef CPU_FPU_TIMEOUT_EN
    logic [9:0] wd_cnt;

    assign timeout_hit = busy_state && (wd_cnt == WD_LIMIT);

    // Cleared on every state entry so each handshake phase gets its own budget.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wd_cnt <= 10'd0;
        end else if (state_next != state) begin
            wd_cnt <= 10'd0;
        end else if (busy_state) begin
            wd_cnt <= wd_cnt + 10'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
    assign unused_cfg  = ^WD_LIMIT;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_issue) state_next = i_ready[i_unit] ? DRAIN : REQUEST;
            end
            DONE: begin
                state_next = IDLE;
                if (i_issue) state_next = i_ready[i_unit] ? DRAIN : REQUEST;
            end
            DRAIN: begin
                if (!ready_sel) state_next = REQUEST;
            end
            REQUEST: begin
                if (ready_sel) state_next = RELEASE;
            end
            RELEASE: begin
                if (!ready_sel) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit) state_next = DONE;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            unit      <= 2'd0;
            o_op1     <= 32'd0;
            o_op2     <= 32'd0;
            o_request <= 4'd0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= 32'd0;
        end else begin
            unit <= unit_next;
            if (issue_take) begin
                o_op1 <= i_op1;
                o_op2 <= i_op2;
            end
            o_request <= (state_next == REQUEST) ? (4'b0001 << unit_next) : 4'd0;
            o_busy    <= (state_next == DRAIN) || (state_next == REQUEST) ||
                         (state_next == RELEASE);
            o_done    <= (state_next == DONE);
            if (timeout_hit) begin
                o_result <= QUIET_NAN;
            end else if ((state == REQUEST) && ready_sel) begin
                o_result <= result_sel;
            end
        end
    end

endmodule

// File: tb/tb_cpu_fpu_requester.sv
// Directed bench for cpu_fpu_requester: vector table of FP operations plus hand sequences
// for back-to-back issue, stale ready, asynchronous reset and (with CPU_FPU_TIMEOUT_EN) watchdog.
`timescale 1ns/1ps
module tb_cpu_fpu_requester;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_issue;
    logic [1:0]   i_unit;
    logic [31:0]  i_op1;
    logic [31:0]  i_op2;
    logic         o_busy;
    logic         o_done;
    logic [31:0]  o_result;
    logic         o_timeout;
    logic [3:0]   o_request;
    logic [31:0]  o_op1;
    logic [31:0]  o_op2;
    logic [3:0]   i_ready;
    logic [127:0] i_result;
    logic [2:0]   o_state;

`ifdef CPU_FPU_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1023;
`endif

    cpu_fpu_requester #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_issue   (i_issue),
        .i_unit    (i_unit),
        .i_op1     (i_op1),
        .i_op2     (i_op2),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_result  (o_result),
        .o_timeout (o_timeout),
        .o_request (o_request),
        .o_op1     (o_op1),
        .o_op2     (o_op2),
        .i_ready   (i_ready),
        .i_result  (i_result),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    int         done_cnt  = 0;
    logic [1:0] cur_unit  = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Done pulses counted at the rising edge (pre-update value).
    always @(posedge clk) if (o_done === 1'b1) done_cnt++;

    // Only the targeted unit's request bit may ever rise.
    always @(negedge clk) begin
        logic [3:0] other;
        other = ~(4'b0001 << cur_unit);
        if (rst === 1'b0 && o_request !== 4'd0) chk("req_other_unit", 32'(o_request & other), 32'd0);
    end

    typedef struct {
        logic [1:0]  unit;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    // Called at a falling edge; returns at the falling edge where o_done is high.
    task automatic run_op(input logic [1:0] u, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int lat, input bit poke);
        cur_unit = u;
        i_issue  = 1'b1;
        i_unit   = u;
        i_op1    = a;
        i_op2    = b;
        for (int k = 0; k < 4; k++) i_result[k*32 +: 32] = 32'hDEAD_0000 | 32'(k);
        i_result[u*32 +: 32] = r;
        @(negedge clk);
        i_issue = 1'b0;
        chk("req_assert", 32'(o_request), 32'(4'b0001 << u));
        chk("busy_high", 32'(o_busy), 32'd1);
        chk("op1_bus", o_op1, a);
        chk("op2_bus", o_op2, b);
        for (int i = 1; i < lat; i++) begin
            if (poke && i == 1) begin
                i_issue = 1'b1;
                i_unit  = ~u;
                i_op1   = ~a;
                i_op2   = ~b;
            end
            @(negedge clk);
            i_issue = 1'b0;
            chk("req_hold", 32'(o_request), 32'(4'b0001 << u));
            chk("op1_hold", o_op1, a);
        end
        i_ready[u] = 1'b1;
        @(negedge clk);
        chk("req_drop", 32'(o_request), 32'd0);
        chk("result_capture", o_result, r);
        chk("done_early", 32'(o_done), 32'd0);
        i_ready[u] = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("done_result", o_result, r);
        chk("done_busy", 32'(o_busy), 32'd0);
        chk("done_timeout", 32'(o_timeout), 32'd0);
        chk("done_state", 32'(o_state), 32'd4);
    endtask

    initial begin
        int d0;
        int n;

        vecs[0] = '{unit: 2'd2, op1: 32'h40C0_0000, op2: 32'h4000_0000, res: 32'h4040_0000, lat: 3};
        vecs[1] = '{unit: 2'd0, op1: 32'h3F80_0000, op2: 32'h3F80_0000, res: 32'h4000_0000, lat: 1};
        vecs[2] = '{unit: 2'd1, op1: 32'h4040_0000, op2: 32'h4000_0000, res: 32'h40C0_0000, lat: 2};
        vecs[3] = '{unit: 2'd3, op1: 32'h4080_0000, op2: 32'h0000_0000, res: 32'h4000_0000, lat: 4};
        vecs[4] = '{unit: 2'd0, op1: 32'h3FC0_0000, op2: 32'h4020_0000, res: 32'h4080_0000, lat: 2};
        vecs[5] = '{unit: 2'd1, op1: 32'hC000_0000, op2: 32'h3F00_0000, res: 32'hBF80_0000, lat: 2};

        rst      = 1'b1;
        i_issue  = 1'b0;
        i_unit   = 2'd0;
        i_op1    = 32'd0;
        i_op2    = 32'd0;
        i_ready  = 4'd0;
        i_result = 128'd0;
        repeat (3) @(negedge clk);
        chk("rst_request", 32'(o_request), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_op1", o_op1, 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table; the first (divide) also pulses an ignored issue while busy.
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            run_op(vecs[i].unit, vecs[i].op1, vecs[i].op2, vecs[i].res, vecs[i].lat, i == 0);
            @(negedge clk);
            chk("idle_done_low", 32'(o_done), 32'd0);
            chk("idle_state", 32'(o_state), 32'd0);
            chk("single_done", 32'(done_cnt - d0), 32'd1);
        end

        // Back-to-back: second issue lands in the first operation's DONE cycle.
        d0 = done_cnt;
        run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 2, 1'b0);
        run_op(2'd1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 2, 1'b0);
        @(negedge clk);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // Stale ready on unit 1 at issue.
        cur_unit = 2'd1;
        i_ready  = 4'b0010;
        i_issue  = 1'b1;
        i_unit   = 2'd1;
        i_op1    = 32'h3FC0_0000;
        i_op2    = 32'h4000_0000;
        i_result = {4{32'h1111_1111}};
        repeat (3) begin
            @(negedge clk);
            i_issue = 1'b0;
            chk("stale_req_low", 32'(o_request), 32'd0);
            chk("stale_busy", 32'(o_busy), 32'd1);
            chk("stale_no_capture", o_result, 32'h40C0_0000);
            chk("stale_state", 32'(o_state), 32'd1);
        end
        i_ready = 4'd0;
        @(negedge clk);
        chk("stale_req_rise", 32'(o_request), 32'b0010);
        i_result[63:32] = 32'h4040_0000;
        i_ready = 4'b0010;
        @(negedge clk);
        chk("stale_result", o_result, 32'h4040_0000);
        i_ready = 4'd0;
        @(negedge clk);
        chk("stale_done", 32'(o_done), 32'd1);
        @(negedge clk);

        // Asynchronous reset while requesting.
        cur_unit = 2'd0;
        i_issue  = 1'b1;
        i_unit   = 2'd0;
        i_op1    = 32'h3F80_0000;
        i_op2    = 32'h4000_0000;
        @(negedge clk);
        i_issue = 1'b0;
        chk("pre_rst_req", 32'(o_request), 32'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_request", 32'(o_request), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        chk("async_rst_result", o_result, 32'd0);
        chk("async_rst_op1", o_op1, 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_idle", 32'(o_state), 32'd0);
        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2, 1'b0);
        @(negedge clk);

`ifdef CPU_FPU_TIMEOUT_EN
        // Unit 3 never answers; the watchdog must end the operation with a quiet NaN.
        cur_unit = 2'd3;
        i_issue  = 1'b1;
        i_unit   = 2'd3;
        i_op1    = 32'h4110_0000;
        i_op2    = 32'd0;
        @(negedge clk);
        i_issue = 1'b0;
        n = 0;
        while (o_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_done", 32'(o_done), 32'd1);
        chk("to_flag", 32'(o_timeout), 32'd1);
        chk("to_result", o_result, 32'h7FC0_0000);
        chk("to_request", 32'(o_request), 32'd0);
        chk("to_latency", 32'(n >= 14 && n <= 18), 32'd1);
        @(negedge clk);
        chk("to_flag_clear", 32'(o_timeout), 32'd0);
`else
        n = 0;
        chk("timeout_tied_low", 32'(o_timeout), 32'(n));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
